cim_tile_sequencer: RTL

//  Autonomous sequencer for one CIM matrix-vector tile. It sits beside the darkriscv core and drives the same CIM macro port
//  (write/cim/partial_sum/reset_output/output_reg/address/input_data), so software no longer issues per-chunk CIM instructions.
//  On start it: clears the output registers, streams CFG_K input words from data memory into partial-sum compute ops, then reads
//  CFG_NOUT output registers back into data memory. A mux outside this block selects between core and sequencer; busy drives that mux.

---
 rtl/cim_tile_sequencer_if.sv | 55 +++++
 rtl/cim_tile_sequencer.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/cim_tile_sequencer_if.sv
// -----------------------------------------------------------------------------
// cim_tile_sequencer_if
// Bundles the sequencer's three buses: the host control/config channel, the
// data-memory port and the CIM macro port.
//   host   : start, cfg_wbase/xbase/obase, cfg_k, cfg_nout -> busy, done, err
//   memory : mem_rd, mem_wr, mem_addr, mem_wdata -> mem_rdata (1-cycle read)
//   CIM    : write, cim, partial_sum, reset_output, output_reg, address,
//            input_data -> cim_output
// modport master : sequencer side (drives strobes and addresses)
// modport slave  : host / memory / macro side
// -----------------------------------------------------------------------------
interface cim_tile_sequencer_if;
   logic        start;
   logic [31:0] cfg_wbase;
   logic [31:0] cfg_xbase;
   logic [31:0] cfg_obase;
   logic [15:0] cfg_k;
   logic [4:0]  cfg_nout;
   logic        busy;
   logic        done;
   logic        err;

   logic        mem_rd;
   logic        mem_wr;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;

   logic        write;
   logic        cim;
   logic        partial_sum;
   logic        reset_output;
   logic [3:0]  output_reg;
   logic [31:0] address;
   logic [31:0] input_data;
   logic [31:0] cim_output;

   modport master (
      input  start, cfg_wbase, cfg_xbase, cfg_obase, cfg_k, cfg_nout,
      output busy, done, err,
      output mem_rd, mem_wr, mem_addr, mem_wdata,
      input  mem_rdata,
      output write, cim, partial_sum, reset_output, output_reg, address, input_data,
      input  cim_output
   );

   modport slave (
      output start, cfg_wbase, cfg_xbase, cfg_obase, cfg_k, cfg_nout,
      input  busy, done, err,
      input  mem_rd, mem_wr, mem_addr, mem_wdata,
      output mem_rdata,
      input  write, cim, partial_sum, reset_output, output_reg, address, input_data,
      output cim_output
   );
endinterface

// File: rtl/cim_tile_sequencer.sv
// -----------------------------------------------------------------------------
// cim_tile_sequencer
// Autonomous sequencer for one CIM matrix-vector tile. On start it clears the
// CIM output registers, streams cfg_k input words from data memory into
// partial-sum compute ops, then copies cfg_nout CIM output registers back to
// data memory. busy steers the external core/sequencer mux.
// Ports:
//   clk_i  : clock
//   rst_i  : synchronous active-high reset, aborts any run immediately
//   hlt_i  : freeze; state and counters held, all strobes forced low
//   bus    : cim_tile_sequencer_if.master (host, memory and CIM buses)
// Parameters:
//   NREG       : number of CIM output registers (max cfg_nout)
//   WSTRIDE    : byte step of the CIM weight address per K chunk
//   CIM_RD_LAT : cycles from output_reg issue to valid cim_output (0 or 1)
// -----------------------------------------------------------------------------
module cim_tile_sequencer #(
   parameter int NREG       = 16,
   parameter int WSTRIDE    = 4,
   parameter int CIM_RD_LAT = 1
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 hlt_i,
   cim_tile_sequencer_if.master bus
);

   typedef enum logic [3:0] {
      S_IDLE,
      S_ERR,
      S_CLR,
      S_FETCH,
      S_COMP,
      S_RDREG,
      S_WAIT,
      S_STORE,
      S_DONE
   } state_t;

   localparam logic [5:0]  NREG_L    = 6'(NREG);
   localparam logic [31:0] WSTRIDE_L = 32'(WSTRIDE);

   state_t      state_q, state_d;
   logic [15:0] k_q, k_d;
   logic [4:0]  r_q, r_d;
   logic        cfg_ld;
   logic        cfg_bad;
   logic        run;

   logic [31:0] wbase_q;
   logic [31:0] xbase_q;
   logic [31:0] obase_q;
   logic [15:0] cfg_k_q;
   logic [4:0]  cfg_nout_q;

   logic [31:0] mem_addr_q;
   logic [31:0] address_q;
   logic [31:0] mem_wdata_q;
   logic [31:0] rdata_q;
   logic [3:0]  output_reg_q;
   logic        fetch_iss_q;
   logic        rd_iss_q;
   logic        cap_en;

   // Outside IDLE every op is suppressed while frozen and reissued afterwards.
   assign run = ~hlt_i;

   assign cfg_bad = (bus.cfg_k == 16'd0) | (bus.cfg_nout == 5'd0) |
                    ({1'b0, bus.cfg_nout} > NREG_L);

   // cim_output is captured once, on the cycle it becomes valid after an
   // issued RDREG, even if hlt_i is high then; the stored value is what STORE
   // writes, so a later freeze cannot lose or corrupt it.
   assign cap_en = (CIM_RD_LAT == 0) ? ((state_q == S_RDREG) & run) : rd_iss_q;

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      r_d     = r_q;
      cfg_ld  = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               if (cfg_bad) begin
                  state_d = S_ERR;
               end else begin
                  state_d = S_CLR;
                  cfg_ld  = 1'b1;
               end
            end
         end
         S_ERR: begin
            if (run) state_d = S_IDLE;
         end
         S_CLR: begin
            if (run) begin
               state_d = S_FETCH;
               k_d     = 16'd0;
            end
         end
         S_FETCH: begin
            if (run) state_d = S_COMP;
         end
         S_COMP: begin
            if (run) begin
               if (k_q == cfg_k_q - 16'd1) begin
                  state_d = S_RDREG;
                  r_d     = 5'd0;
               end else begin
                  state_d = S_FETCH;
                  k_d     = k_q + 16'd1;
               end
            end
         end
         S_RDREG: begin
            if (run) begin
               if (CIM_RD_LAT != 0) state_d = S_WAIT;
               else                 state_d = S_STORE;
            end
         end
         S_WAIT: begin
            if (run) state_d = S_STORE;
         end
         S_STORE: begin
            if (run) begin
               if (r_q == cfg_nout_q - 5'd1) begin
                  state_d = S_DONE;
               end else begin
                  state_d = S_RDREG;
                  r_d     = r_q + 5'd1;
               end
            end
         end
         S_DONE: begin
            if (run) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Strobes decode the registered state; a frozen cycle issues nothing.
   always_comb begin
      bus.busy         = (state_q != S_IDLE) && (state_q != S_ERR);
      bus.done         = 1'b0;
      bus.err          = 1'b0;
      bus.mem_rd       = 1'b0;
      bus.mem_wr       = 1'b0;
      bus.cim          = 1'b0;
      bus.partial_sum  = 1'b0;
      bus.reset_output = 1'b0;
      if (run) begin
         unique case (state_q)
            S_ERR: begin
               bus.done = 1'b1;
               bus.err  = 1'b1;
            end
            S_CLR: begin
               bus.cim          = 1'b1;
               bus.reset_output = 1'b1;
            end
            S_FETCH: bus.mem_rd = 1'b1;
            S_COMP: begin
               bus.cim         = 1'b1;
               bus.partial_sum = 1'b1;
            end
            S_RDREG: bus.cim    = 1'b1;
            S_STORE: bus.mem_wr = 1'b1;
            S_DONE:  bus.done   = 1'b1;
            default: ;
         endcase
      end
   end

   // Weights are preloaded by the core; the sequencer never writes them.
   assign bus.write      = 1'b0;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_wdata  = mem_wdata_q;
   assign bus.address    = address_q;
   assign bus.output_reg = output_reg_q;
   // The first COMP cycle after a FETCH forwards the live read data; a COMP
   // reissued after a freeze uses the copy captured on that first cycle.
   assign bus.input_data = fetch_iss_q ? bus.mem_rdata : rdata_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= S_IDLE;
         k_q          <= 16'd0;
         r_q          <= 5'd0;
         fetch_iss_q  <= 1'b0;
         rd_iss_q     <= 1'b0;
         rdata_q      <= 32'd0;
         mem_wdata_q  <= 32'd0;
         mem_addr_q   <= 32'd0;
         address_q    <= 32'd0;
         output_reg_q <= 4'd0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         r_q         <= r_d;
         fetch_iss_q <= (state_q == S_FETCH) & run;
         rd_iss_q    <= (state_q == S_RDREG) & run;
         if (fetch_iss_q) rdata_q     <= bus.mem_rdata;
         if (cap_en)      mem_wdata_q <= bus.cim_output;
         // Addresses are loaded on entry to the state that presents them.
         unique case (state_d)
            S_FETCH: mem_addr_q   <= xbase_q + {14'd0, k_d, 2'b00};
            S_COMP:  address_q    <= wbase_q + WSTRIDE_L * {16'd0, k_d};
            S_RDREG: output_reg_q <= r_d[3:0];
            S_STORE: mem_addr_q   <= obase_q + {25'd0, r_d, 2'b00};
            default: ;
         endcase
      end
   end

   // Configuration is only sampled on an accepted start.
   always_ff @(posedge clk_i) begin
      if (cfg_ld) begin
         wbase_q    <= bus.cfg_wbase;
         xbase_q    <= bus.cfg_xbase;
         obase_q    <= bus.cfg_obase;
         cfg_k_q    <= bus.cfg_k;
         cfg_nout_q <= bus.cfg_nout;
      end
   end

endmodule
